// File: rtl/pong_pkg.sv
// Shared rally types: FSM states, playfield geometry and theta helpers.
// Theta is a 6-bit angle; 0 points right, 16 down, 32 left, 48 up.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    OVER
  } state_e;

  localparam int THETA_WIDTH = 6;
  localparam int FIELD_W     = 16;
  localparam int FIELD_H     = 8;

  typedef logic [THETA_WIDTH-1:0] theta_t;

  localparam theta_t DIR_RIGHT = 6'd0;
  localparam theta_t DIR_LEFT  = 6'd32;

  function automatic logic is_right(theta_t t);
    return (t < 6'd16) || (t >= 6'd48);
  endfunction

  function automatic logic is_left(theta_t t);
    return (t >= 6'd17) && (t <= 6'd47);
  endfunction

  function automatic logic is_down(theta_t t);
    return (t >= 6'd1) && (t <= 6'd31);
  endfunction

  function automatic logic is_up(theta_t t);
    return t >= 6'd33;
  endfunction

endpackage

// File: rtl/rally_bounce.sv
// Combinational ball deflection: wall reflection, paddle hit with
// edge steering and angle clamp, plus miss detection.
module rally_bounce
  import pong_pkg::*;
#(
  parameter int PADDLE_H = 3
) (
  input  logic [THETA_WIDTH-1:0] theta_i,
  input  logic [3:0]             ball_x,
  input  logic [3:0]             ball_y,
  input  logic [3:0]             paddle_l,
  input  logic [3:0]             paddle_r,
  output logic [THETA_WIDTH-1:0] theta_o,
  output logic                   hit_o,
  output logic                   miss_l_o,
  output logic                   miss_r_o
);

  theta_t     theta_w;
  theta_t     base;
  theta_t     off;
  theta_t     res;
  logic [4:0] top;
  logic [4:0] bot;
  logic [4:0] y5;
  logic       hit_l;
  logic       hit_r;

  always_comb begin
    theta_w = theta_i;
    if ((ball_y == 4'(FIELD_H - 1) && is_down(theta_i)) ||
        (ball_y == 4'd0 && is_up(theta_i)))
      theta_w = 6'd0 - theta_i;

    hit_l    = (ball_x == 4'd1) && is_left(theta_w);
    hit_r    = (ball_x == 4'(FIELD_W - 2)) && is_right(theta_w);
    miss_l_o = (ball_x == 4'd0) && is_left(theta_w);
    miss_r_o = (ball_x == 4'(FIELD_W - 1)) && is_right(theta_w);

    // 5-bit window so a paddle near row 15 cannot wrap to row 0
    top   = hit_r ? {1'b0, paddle_r} : {1'b0, paddle_l};
    bot   = top + 5'(PADDLE_H - 1);
    y5    = {1'b0, ball_y};
    hit_o = (hit_l || hit_r) && (y5 >= top) && (y5 <= bot);

    // upward steer is +4 on a leftward result, -4 on a rightward one
    base = DIR_LEFT - theta_w;
    off  = 6'd0;
    if (y5 == top)
      off = hit_r ? 6'd4 : 6'd60;
    else if (y5 == bot)
      off = hit_r ? 6'd60 : 6'd4;
    res = base + off;

    theta_o = theta_w;
    if (hit_o) begin
      if (hit_r) begin
        if (res < 6'd20)
          theta_o = 6'd20;
        else if (res > 6'd44)
          theta_o = 6'd44;
        else
          theta_o = res;
      end else begin
        if (res > 6'd12 && res < 6'd32)
          theta_o = 6'd12;
        else if (res >= 6'd32 && res < 6'd52)
          theta_o = 6'd52;
        else
          theta_o = res;
      end
    end
  end

endmodule

// File: rtl/rally_ctrl.sv
// Pong rally controller: serve, play, scoring and game-over sequencing.
// Define RALLY_SPEEDUP_EN to speed the ball up on every paddle hit.
module rally_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_H    = 3,
  parameter int SPEED_INIT  = 4,
  parameter int SPEED_MAX   = 15,
  parameter int HOLD_CYCLES = 250,
  parameter int WIN_SCORE   = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ball_x,
  input  logic [3:0]             ball_y,
  input  logic [3:0]             paddle_l,
  input  logic [3:0]             paddle_r,
  output logic [THETA_WIDTH-1:0] theta,
  output logic signed [4:0]      speed,
  output logic                   ball_rst,
  output logic [3:0]             score_l,
  output logic [3:0]             score_r,
  output logic                   game_over
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic signed [4:0] SPD_SERVE =
    5'((SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_e            state_q, state_d;
  theta_t            theta_q, theta_d;
  theta_t            serve_q, serve_d;
  theta_t            bounce_theta;
  logic signed [4:0] speed_q, speed_d;
  logic              ball_rst_q, ball_rst_d;
  logic              over_q, over_d;
  logic [3:0]        score_l_q, score_l_d;
  logic [3:0]        score_r_q, score_r_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hit;
  logic              miss_l;
  logic              miss_r;

  rally_bounce #(
    .PADDLE_H(PADDLE_H)
  ) u_bounce (
    .theta_i (theta_q),
    .ball_x  (ball_x),
    .ball_y  (ball_y),
    .paddle_l(paddle_l),
    .paddle_r(paddle_r),
    .theta_o (bounce_theta),
    .hit_o   (hit),
    .miss_l_o(miss_l),
    .miss_r_o(miss_r)
  );

  always_comb begin
    state_d    = state_q;
    theta_d    = theta_q;
    serve_d    = serve_q;
    speed_d    = speed_q;
    ball_rst_d = ball_rst_q;
    over_d     = over_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    hold_d     = hold_q;

    unique case (state_q)
      IDLE: begin
        speed_d    = '0;
        ball_rst_d = 1'b1;
        if (start) begin
          state_d = SERVE;
          theta_d = serve_q;
          speed_d = SPD_SERVE;
        end
      end
      SERVE: begin
        state_d    = PLAY;
        ball_rst_d = 1'b0;
      end
      PLAY: begin
        theta_d = bounce_theta;
        if (miss_l || miss_r) begin
          state_d = POINT;
          speed_d = '0;
          hold_d  = '0;
          if (miss_l) begin
            if (score_r_q < WIN)
              score_r_d = score_r_q + 4'd1;
            serve_d = DIR_LEFT;
          end else begin
            if (score_l_q < WIN)
              score_l_d = score_l_q + 4'd1;
            serve_d = DIR_RIGHT;
          end
        end
`ifdef RALLY_SPEEDUP_EN
        else if (hit && (speed_q < 5'(SPEED_MAX)))
          speed_d = speed_q + 5'sd1;
`endif
      end
      POINT: begin
        speed_d = '0;
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_d     = '0;
          ball_rst_d = 1'b1;
          if (score_l_q == WIN || score_r_q == WIN) begin
            state_d = OVER;
            over_d  = 1'b1;
          end else begin
            state_d = SERVE;
            theta_d = serve_q;
            speed_d = SPD_SERVE;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      OVER: begin
        speed_d = '0;
        over_d  = 1'b1;
        if (start) begin
          state_d    = SERVE;
          over_d     = 1'b0;
          score_l_d  = '0;
          score_r_d  = '0;
          theta_d    = serve_q;
          speed_d    = SPD_SERVE;
          ball_rst_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      theta_q    <= '0;
      serve_q    <= DIR_RIGHT;
      speed_q    <= '0;
      ball_rst_q <= 1'b1;
      over_q     <= 1'b0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      theta_q    <= theta_d;
      serve_q    <= serve_d;
      speed_q    <= speed_d;
      ball_rst_q <= ball_rst_d;
      over_q     <= over_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      hold_q     <= hold_d;
    end
  end

  assign theta     = theta_q;
  assign speed     = speed_q;
  assign ball_rst  = ball_rst_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Scoreboard bench for rally_ctrl: stimulus queues expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_rally_ctrl;

  localparam int HOLD = 250;
  localparam int F_TH = 0;
  localparam int F_SP = 1;
  localparam int F_BR = 2;
  localparam int F_SL = 3;
  localparam int F_SR = 4;
  localparam int F_GO = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [3:0]        ball_x;
  logic [3:0]        ball_y;
  logic [3:0]        paddle_l;
  logic [3:0]        paddle_r;
  logic [5:0]        theta;
  logic signed [4:0] speed;
  logic              ball_rst;
  logic [3:0]        score_l;
  logic [3:0]        score_r;
  logic              game_over;

  typedef struct {
    int    cyc;
    string nm;
    int    fld;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   drain  = 1'b0;
  int   exp_spd;

  rally_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .paddle_l (paddle_l),
    .paddle_r (paddle_r),
    .theta    (theta),
    .speed    (speed),
    .ball_rst (ball_rst),
    .score_l  (score_l),
    .score_r  (score_r),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act(int f);
    case (f)
      F_TH:    return int'(theta);
      F_SP:    return int'(speed);
      F_BR:    return int'(ball_rst);
      F_SL:    return int'(score_l);
      F_SR:    return int'(score_r);
      default: return int'(game_over);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (drain) begin
        n_chk++;
        $display("FAIL %s never checked (due cyc %0d, now %0d)",
                 sb[i].nm, sb[i].cyc, cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        n_chk++;
        if (act(sb[i].fld) == sb[i].exp)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                   sb[i].nm, cyc, act(sb[i].fld), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want(int d, string nm, int f, int v);
    exp_t e;
    e.cyc = cyc + d;
    e.nm  = nm;
    e.fld = f;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic bump_spd();
`ifdef RALLY_SPEEDUP_EN
    if (exp_spd < 15)
      exp_spd++;
`endif
  endtask

  // one PLAY cycle with ball at (x,y); expects new theta next cycle
  task automatic step(int x, int y, int pl, int pr, int th, bit h,
                      string nm);
    ball_x   = 4'(x);
    ball_y   = 4'(y);
    paddle_l = 4'(pl);
    paddle_r = 4'(pr);
    want(1, nm, F_TH, th);
    if (h) begin
      bump_spd();
      want(1, {nm, "_spd"}, F_SP, exp_spd);
    end
    tick();
  endtask

  task automatic centre();
    ball_x = 4'd7;
    ball_y = 4'd3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    paddle_l = 4'd0;
    paddle_r = 4'd0;
    centre();
    tick(2);
    reset = 1'b0;
    want(0, "rst_theta", F_TH, 0);
    want(0, "rst_speed", F_SP, 0);
    want(0, "rst_brst", F_BR, 1);
    want(0, "rst_sl", F_SL, 0);
    want(0, "rst_sr", F_SR, 0);
    want(0, "rst_go", F_GO, 0);

    start = 1'b1;
    want(1, "serve_brst", F_BR, 1);
    want(1, "serve_theta", F_TH, 0);
    want(1, "serve_speed", F_SP, 4);
    tick();
    start = 1'b0;
    want(1, "play_brst", F_BR, 0);
    want(1, "play_speed", F_SP, 4);
    tick();
    exp_spd = 4;

    step(14, 5, 0, 4, 32, 1'b1, "r_mid");
    step(14, 5, 0, 4, 32, 1'b0, "r_guard");
    step(1, 4, 2, 4, 4, 1'b1, "l_bot");
    step(7, 7, 2, 4, 60, 1'b0, "wall_y7");
    step(7, 7, 2, 4, 60, 1'b0, "wall_hold1");
    step(7, 7, 2, 4, 60, 1'b0, "wall_hold2");
    step(14, 0, 2, 0, 32, 1'b1, "wall_then_pad");
    step(1, 3, 2, 0, 0, 1'b1, "l_mid");
    step(14, 3, 2, 3, 36, 1'b1, "r_top");
    step(1, 3, 3, 3, 56, 1'b1, "l_top");
    step(14, 3, 3, 3, 44, 1'b1, "r_top_edge44");
    step(1, 3, 3, 3, 52, 1'b1, "l_clamp52");
    step(14, 3, 3, 3, 44, 1'b1, "r_clamp44");
    step(1, 6, 3, 3, 44, 1'b0, "l_window_out");

    ball_x = 4'd0;
    ball_y = 4'd6;
    want(1, "miss_speed", F_SP, 0);
    want(1, "miss_sr", F_SR, 1);
    want(1, "miss_sl", F_SL, 0);
    tick();
    centre();
    want(HOLD - 1, "hold_speed", F_SP, 0);
    want(HOLD, "reserve_theta", F_TH, 32);
    want(HOLD, "reserve_speed", F_SP, 4);
    want(HOLD, "reserve_brst", F_BR, 1);
    want(HOLD + 1, "reserve_play", F_BR, 0);
    tick(HOLD + 1);

    for (int k = 2; k <= 9; k++) begin
      ball_x = 4'd0;
      ball_y = 4'd3;
      want(1, $sformatf("sr_%0d", k), F_SR, k);
      tick();
      centre();
      if (k < 9) begin
        tick(HOLD + 1);
      end else begin
        want(HOLD - 1, "go_before", F_GO, 0);
        want(HOLD, "go_over", F_GO, 1);
        want(HOLD, "go_speed", F_SP, 0);
        want(HOLD + 1, "go_sr_sat", F_SR, 9);
        tick(HOLD + 1);
      end
    end

    start = 1'b1;
    want(1, "restart_sr", F_SR, 0);
    want(1, "restart_go", F_GO, 0);
    want(1, "restart_theta", F_TH, 32);
    want(1, "restart_speed", F_SP, 4);
    tick();
    start = 1'b0;
    tick();
    exp_spd = 4;
    step(1, 3, 2, 3, 0, 1'b1, "l_mid2");
    ball_x = 4'd15;
    ball_y = 4'd3;
    want(1, "rmiss_sl", F_SL, 1);
    want(1, "rmiss_speed", F_SP, 0);
    tick();
    centre();
    tick(5);

    reset = 1'b1;
    want(1, "midrst_theta", F_TH, 0);
    want(1, "midrst_speed", F_SP, 0);
    want(1, "midrst_brst", F_BR, 1);
    want(1, "midrst_sl", F_SL, 0);
    want(1, "midrst_go", F_GO, 0);
    tick();
    reset = 1'b0;
    want(1, "idle_speed", F_SP, 0);
    tick();
    start = 1'b1;
    want(1, "rst_serve_dir", F_TH, 0);
    want(1, "rst_serve_spd", F_SP, 4);
    tick();
    start = 1'b0;
    tick(2);

    @(negedge clk);
    #1;
    drain = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
